mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit in the EX stage, directly downstream of the forwarding operand multiplexers. It consumes the two forwarded 32-bit operands plus funct3 and runs every M-extension operation in a fixed 33-cycle sequence. Throughout that sequence it drives BUSY so the hazard unit can stall IF/ID/EX. On completion it presents a registered RESULT with a one-cycle DONE pulse for the EX/MEM register.

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - EX-stage request/response bundle for the iterative mul/div unit
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  // pipeline side: issues operations, observes completion
  modport master (
    output start, flush, funct3, operand1, operand2,
    input  result, busy, done
  );

  // execution unit side
  modport slave (
    input  start, flush, funct3, operand1, operand2,
    output result, busy, done
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, fixed 33-cycle latency
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   sh_q;        // multiplier bits (mul) / dividend bits then quotient (div)
  logic [XLEN-1:0]   b_q;         // multiplicand / divisor magnitude
  logic [XLEN-1:0]   a_orig_q;    // raw rs1, returned by REM* on divide-by-zero
  logic [2*XLEN-1:0] acc_q;       // product accumulator / partial remainder in low half
  logic [CW-1:0]     cnt_q;
  logic              a_neg_q, b_neg_q, b_zero_q, ovf_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              rs1_signed, rs2_signed, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [2*XLEN-1:0] mul_acc_next;
  logic [XLEN:0]     rem_shift;
  logic              q_bit;
  logic [XLEN-1:0]   rem_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fin_val;

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // operand sign decode and magnitude extraction for the accept edge
  always_comb begin
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    case (bus.funct3)
      3'b001, 3'b100, 3'b110: begin rs1_signed = 1'b1; rs2_signed = 1'b1; end
      3'b010:                 rs1_signed = 1'b1;
      default:                ;
    endcase
    a_neg_in = rs1_signed & bus.operand1[XLEN-1];
    b_neg_in = rs2_signed & bus.operand2[XLEN-1];
    a_mag_in = a_neg_in ? -bus.operand1 : bus.operand1;
    b_mag_in = b_neg_in ? -bus.operand2 : bus.operand2;
  end

  // one MSB-first iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_acc_next = {acc_q[2*XLEN-2:0], 1'b0} + (sh_q[XLEN-1] ? {{XLEN{1'b0}}, b_q} : '0);
    rem_shift    = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
    q_bit        = (rem_shift >= {1'b0, b_q});
    rem_next     = q_bit ? XLEN'(rem_shift - {1'b0, b_q}) : rem_shift[XLEN-1:0];
  end

  // sign correction, result selection and the divide corner-case overrides
  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quot = (a_neg_q ^ b_neg_q) ? -sh_q : sh_q;
    rem  = a_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    case (op_q)
      3'b000:                 fin_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_val = quot;
      default:                fin_val = rem;
    endcase
    if (op_q[2] && b_zero_q)
      fin_val = op_q[1] ? a_orig_q : '1;
    else if (op_q[2] && ovf_q)
      fin_val = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state: a flush always wins, even over a start in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == CW'(XLEN-1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // datapath: latch on accept, iterate in CALC, publish in FIN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      sh_q     <= '0;
      b_q      <= '0;
      a_orig_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (bus.start) begin
            op_q     <= bus.funct3;
            sh_q     <= a_mag_in;
            b_q      <= b_mag_in;
            a_orig_q <= bus.operand1;
            a_neg_q  <= a_neg_in;
            b_neg_q  <= b_neg_in;
            b_zero_q <= (bus.operand2 == '0);
            ovf_q    <= bus.funct3[2] && !bus.funct3[0] &&
                        (bus.operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.operand2 == '1);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
          CALC: begin
            if (op_q[2]) begin
              acc_q <= {{XLEN{1'b0}}, rem_next};
              sh_q  <= {sh_q[XLEN-2:0], q_bit};
            end else begin
              acc_q <= mul_acc_next;
              sh_q  <= {sh_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 1'b1;
          end
          FIN: begin
            result_q <= fin_val;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed bench for mul_div_unit
module tb_mul_div_unit;
  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // issue one op at a negedge, optionally re-pulse start at CALC cycle repulse_at
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int repulse_at);
    int cycles;
    int busy_n;
    bus.funct3   = f3;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.operand1 = $urandom;
    bus.operand2 = $urandom;
    bus.funct3   = 3'($urandom);
    cycles = 0;
    busy_n = 0;
    while (!bus.done && cycles < 100) begin
      if (bus.busy) busy_n++;
      bus.start = (cycles == repulse_at);
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_res"}, bus.result, exp);
    check({tag, "_lat"}, 32'(cycles), 32'd33);
    check({tag, "_busy_n"}, 32'(busy_n), 32'd33);
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic expect_no_done(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.funct3   = 3'd0;
    bus.operand1 = '0;
    bus.operand2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, -1);
    run_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, -1);
    run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, -1);
    run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    run_op("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, -1);
    run_op("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, -1);
    run_op("divu",     3'b101, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, -1);
    run_op("remu",     3'b111, 32'd10,       32'd3,        32'd1,        -1);
    run_op("div_z",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, -1);
    run_op("remu_z",   3'b111, 32'd5,        32'd0,        32'd5,        -1);
    run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, -1);
    run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        -1);
    run_op("repulse",  3'b000, 32'd6,        32'd7,        32'd42,       5);

    // flush at edge e10 of a DIVU
    bus.funct3   = 3'b101;
    bus.operand1 = 32'd100;
    bus.operand2 = 32'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    expect_no_done("flush_no_done", 40);
    check("flush_result", bus.result, 32'd42);

    // flush and start together in IDLE
    bus.funct3   = 3'b000;
    bus.operand1 = 32'd9;
    bus.operand2 = 32'd9;
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("fs_busy", {31'd0, bus.busy}, 32'd0);
    expect_no_done("fs_no_done", 40);
    check("fs_result", bus.result, 32'd42);

    // async reset mid-CALC
    bus.funct3   = 3'b000;
    bus.operand1 = 32'd5;
    bus.operand2 = 32'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
